game_flow_controller: RTL and testbench

//  Frame-level sequencer for the game. Per frame, collects the collision events raised by the

---
 rtl/game_pkg.sv | 44 ++++
 rtl/game_flow_controller_if.sv | 43 ++++
 rtl/game_flow_controller_frame_event_latch.sv | 34 +++
 rtl/game_flow_controller.sv | 156 +++++++++++++++
 tb/tb_game_flow_controller.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Brief    : Shared types, default constants and BCD helper for the game
//             frame-flow controller.
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        FREEZE    = 3'd2,
        PAUSE     = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    // Default tuning values for the controller parameters
    localparam int c_init_lives    = 3;
    localparam int c_max_lives     = 5;
    localparam int c_freeze_frames = 30;
    localparam int c_level_step    = 10;
    localparam int c_max_level     = 7;

    // Bit positions inside the per-frame event vector
    localparam int c_ev_num    = 0;
    localparam int c_ev_hart   = 1;
    localparam int c_ev_border = 2;
    localparam int c_ev_count  = 3;

    // Two-digit BCD increment that sticks at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_controller_if
//  Brief    : Bundle of frame events/keys into the controller and the
//             enable/restart/status outputs back to movement and display.
//  Revision : 1.0 - initial release
// ============================================================================
interface game_flow_controller_if;
    import game_pkg::*;

    logic        startOfFrame;
    logic        hit_number_pulse;
    logic        hart_collision;
    logic        border_collision;
    logic        start_key;
    logic        pause_key;

    logic        objects_enable;
    logic        objects_restart;
    logic [7:0]  score_bcd;
    logic [2:0]  lives;
    logic [2:0]  level;
    game_state_t game_state;
    logic        game_over;

    // Producer of events/keys, consumer of status
    modport master (
        output startOfFrame, hit_number_pulse, hart_collision, border_collision,
               start_key, pause_key,
        input  objects_enable, objects_restart, score_bcd, lives, level,
               game_state, game_over
    );

    // The controller itself
    modport slave (
        input  startOfFrame, hit_number_pulse, hart_collision, border_collision,
               start_key, pause_key,
        output objects_enable, objects_restart, score_bcd, lives, level,
               game_state, game_over
    );

endinterface
`default_nettype wire

// File: rtl/game_flow_controller_frame_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : frame_event_latch
//  Brief    : Sticky per-frame capture of N event inputs. The latched value
//             is the ending frame's history on the startOfFrame clk; an input
//             high on that same clk seeds the new frame.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_event_latch #(
    parameter int N = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         sof,
    input  wire logic [N-1:0] ev_in,
    output logic      [N-1:0] ev_latched
);

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            // Restart capture at frame start, otherwise accumulate
            always_ff @(posedge clk) begin
                if (reset)
                    ev_latched[i] <= 1'b0;
                else if (sof)
                    ev_latched[i] <= ev_in[i];
                else
                    ev_latched[i] <= ev_latched[i] | ev_in[i];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_controller
//  Brief    : Frame-level game sequencer: applies latched collision events to
//             score/lives/level at each frame start and drives object
//             enable/restart and status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module game_flow_controller
    import game_pkg::*;
#(
    parameter int INIT_LIVES    = c_init_lives,
    parameter int MAX_LIVES     = c_max_lives,
    parameter int FREEZE_FRAMES = c_freeze_frames,
    parameter int LEVEL_STEP    = c_level_step,
    parameter int MAX_LEVEL     = c_max_level
) (
    input  wire logic             clk,
    input  wire logic             reset,
    game_flow_controller_if.slave bus
);

    localparam int c_frz_w = (FREEZE_FRAMES > 2) ? $clog2(FREEZE_FRAMES) : 1;

    game_state_t          r_state, w_state;
    logic [7:0]           r_score, w_score;
    logic [2:0]           r_lives, w_lives;
    logic [2:0]           r_level, w_level;
    logic [c_frz_w-1:0]   r_frz,   w_frz;
    logic                 w_restart;
    logic                 r_restart, r_enable, r_game_over;
    logic                 r_start_prev, r_pause_prev;
    logic                 w_start_rise, w_pause_rise;
    logic [c_ev_count-1:0] w_ev;

    // Level derived from the BCD score: 1 + score/LEVEL_STEP, capped
    function automatic logic [2:0] level_from(input logic [7:0] bcd);
        int bin;
        int lvl;
        bin = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        lvl = bin / LEVEL_STEP + 1;
        if (lvl > MAX_LEVEL)
            lvl = MAX_LEVEL;
        return 3'(lvl);
    endfunction

    frame_event_latch #(.N(c_ev_count)) u_event_latch (
        .clk        (clk),
        .reset      (reset),
        .sof        (bus.startOfFrame),
        .ev_in      ({bus.border_collision, bus.hart_collision, bus.hit_number_pulse}),
        .ev_latched (w_ev)
    );

    assign w_start_rise = bus.start_key & ~r_start_prev;
    assign w_pause_rise = bus.pause_key & ~r_pause_prev;

    // Next-state and datapath update decisions
    always_comb begin
        w_state   = r_state;
        w_score   = r_score;
        w_lives   = r_lives;
        w_level   = r_level;
        w_frz     = r_frz;
        w_restart = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state   = PLAY;
                    w_restart = 1'b1;
                    w_score   = 8'h00;
                    w_lives   = 3'(INIT_LIVES);
                    w_level   = 3'd1;
                end
            end
            PLAY: begin
                if (bus.startOfFrame) begin
                    if (w_ev[c_ev_num]) begin
                        w_score = bcd_inc(r_score);
                        w_level = level_from(w_score);
                    end
                    if (w_ev[c_ev_border]) begin
                        // Border wins over hart in the same frame
                        w_lives   = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                        w_restart = 1'b1;
                        if (r_lives <= 3'd1) begin
                            w_state = GAME_OVER;
                        end else begin
                            w_state = FREEZE;
                            w_frz   = c_frz_w'(FREEZE_FRAMES - 1);
                        end
                    end else if (w_ev[c_ev_hart] && (r_lives < 3'(MAX_LIVES))) begin
                        w_lives = r_lives + 3'd1;
                    end
                end
                if ((w_state == PLAY) && w_pause_rise)
                    w_state = PAUSE;
            end
            FREEZE: begin
                if (bus.startOfFrame) begin
                    if (r_frz == '0)
                        w_state = PLAY;
                    else
                        w_frz = r_frz - 1'b1;
                end
            end
            PAUSE: begin
                if (w_pause_rise)
                    w_state = PLAY;
            end
            GAME_OVER: begin
                if (w_start_rise)
                    w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_score      <= 8'h00;
            r_lives      <= 3'(INIT_LIVES);
            r_level      <= 3'd1;
            r_frz        <= '0;
            r_restart    <= 1'b0;
            r_enable     <= 1'b0;
            r_game_over  <= 1'b0;
            // Sampling the key during reset means a held key is not an edge
            r_start_prev <= bus.start_key;
            r_pause_prev <= bus.pause_key;
        end else begin
            r_state      <= w_state;
            r_score      <= w_score;
            r_lives      <= w_lives;
            r_level      <= w_level;
            r_frz        <= w_frz;
            r_restart    <= w_restart;
            r_enable     <= (w_state == PLAY);
            r_game_over  <= (w_state == GAME_OVER);
            r_start_prev <= bus.start_key;
            r_pause_prev <= bus.pause_key;
        end
    end

    assign bus.objects_enable  = r_enable;
    assign bus.objects_restart = r_restart;
    assign bus.score_bcd       = r_score;
    assign bus.lives           = r_lives;
    assign bus.level           = r_level;
    assign bus.game_state      = r_state;
    assign bus.game_over       = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_flow_controller
//  Brief    : Scoreboard bench for game_flow_controller; directed frames push
//             hand-derived expected status snapshots, a monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_controller;
    import game_pkg::*;

    logic clk;
    logic reset;

    game_flow_controller_if bus_if ();

    game_flow_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct packed {
        game_state_t st;
        logic [7:0]  score;
        logic [2:0]  lives;
        logic [2:0]  level;
        logic        en;
        logic        rs;
        logic        go;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Bench-side expected game status
    game_state_t e_state = IDLE;
    int          e_n     = 0;
    int          e_lives = 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic [2:0] exp_level(input int n);
        int l;
        l = 1 + n / 10;
        if (l > 7) l = 7;
        return 3'(l);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input bit rs);
        snap_t s;
        s.st    = e_state;
        s.score = to_bcd(e_n);
        s.lives = 3'(e_lives);
        s.level = exp_level(e_n);
        s.en    = (e_state == PLAY);
        s.rs    = rs;
        s.go    = (e_state == GAME_OVER);
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    // One frame: events in the body, then the startOfFrame clk
    task automatic do_frame(input bit hit, input bit hart, input int bclks);
        int len;
        len = (bclks > 2) ? bclks : 2;
        for (int i = 0; i < len; i++) begin
            bus_if.hit_number_pulse = hit && (i == 0);
            bus_if.hart_collision   = hart && (i < 3);
            bus_if.border_collision = (i < bclks);
            tick();
        end
        bus_if.hit_number_pulse = 1'b0;
        bus_if.hart_collision   = 1'b0;
        bus_if.border_collision = 1'b0;
        bus_if.startOfFrame     = 1'b1;
        tick();
        bus_if.startOfFrame     = 1'b0;
    endtask

    // Monitor: compare DUT status against each queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            snap_t e;
            snap_t a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.st    = bus_if.game_state;
            a.score = bus_if.score_bcd;
            a.lives = bus_if.lives;
            a.level = bus_if.level;
            a.en    = bus_if.objects_enable;
            a.rs    = bus_if.objects_restart;
            a.go    = bus_if.game_over;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d sc=%h lv=%0d lvl=%0d en=%b rs=%b go=%b, expected st=%0d sc=%h lv=%0d lvl=%0d en=%b rs=%b go=%b",
                         nm, a.st, a.score, a.lives, a.level, a.en, a.rs, a.go,
                         e.st, e.score, e.lives, e.level, e.en, e.rs, e.go);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus_if.startOfFrame     = 1'b0;
        bus_if.hit_number_pulse = 1'b0;
        bus_if.hart_collision   = 1'b0;
        bus_if.border_collision = 1'b0;
        bus_if.start_key        = 1'b0;
        bus_if.pause_key        = 1'b0;
        tick();
        tick();
        chk("reset", 1'b0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 1'b0);

        // Start the game
        bus_if.start_key = 1'b1;
        tick();
        e_state = PLAY;
        chk("start", 1'b1);
        bus_if.start_key = 1'b0;
        tick();
        chk("start_restart_drop", 1'b0);

        // Ten hits -> 10, level 2
        for (int f = 0; f < 10; f++) begin
            do_frame(1'b1, 1'b0, 0);
            e_n++;
            chk("score_inc", 1'b0);
        end

        // Up to 99, then saturation
        for (int f = 0; f < 89; f++) do_frame(1'b1, 1'b0, 0);
        e_n = 99;
        chk("score_99", 1'b0);
        do_frame(1'b1, 1'b0, 0);
        chk("score_sat", 1'b0);

        // Long border contact -> one life lost, freeze
        do_frame(1'b0, 1'b0, 50);
        e_lives = 2;
        e_state = FREEZE;
        chk("border_freeze", 1'b1);
        for (int f = 0; f < 29; f++) do_frame(1'b1, 1'b0, 0);
        chk("freeze_29", 1'b0);
        do_frame(1'b1, 1'b0, 0);
        e_state = PLAY;
        chk("freeze_end", 1'b0);

        // Hart and border in one frame -> border only
        do_frame(1'b0, 1'b1, 5);
        e_lives = 1;
        e_state = FREEZE;
        chk("hart_border", 1'b1);
        for (int f = 0; f < 30; f++) do_frame(1'b0, 1'b0, 0);
        e_state = PLAY;
        chk("freeze_end2", 1'b0);

        // Last life lost -> game over
        do_frame(1'b0, 1'b0, 3);
        e_lives = 0;
        e_state = GAME_OVER;
        chk("game_over", 1'b1);
        tick();
        chk("game_over_hold", 1'b0);
        bus_if.start_key = 1'b1;
        tick();
        e_state = IDLE;
        chk("go_to_idle", 1'b0);
        bus_if.start_key = 1'b0;
        tick();
        bus_if.start_key = 1'b1;
        tick();
        e_state = PLAY;
        e_n = 0;
        e_lives = 3;
        chk("restart_game", 1'b1);
        bus_if.start_key = 1'b0;
        tick();

        // Hart bonus with saturation
        do_frame(1'b0, 1'b1, 0);
        e_lives = 4;
        chk("hart_4", 1'b0);
        do_frame(1'b0, 1'b1, 0);
        e_lives = 5;
        chk("hart_5", 1'b0);
        do_frame(1'b0, 1'b1, 0);
        chk("hart_sat", 1'b0);

        // Pause holds score
        do_frame(1'b1, 1'b0, 0);
        e_n = 1;
        chk("pre_pause", 1'b0);
        bus_if.pause_key = 1'b1;
        tick();
        e_state = PAUSE;
        chk("pause", 1'b0);
        bus_if.pause_key = 1'b0;
        do_frame(1'b1, 1'b0, 0);
        chk("pause_hold", 1'b0);
        bus_if.pause_key = 1'b1;
        tick();
        e_state = PLAY;
        chk("unpause", 1'b0);
        bus_if.pause_key = 1'b0;
        do_frame(1'b0, 1'b0, 0);
        chk("unpause_clean", 1'b0);

        // Hit on the SOF clk belongs to the next frame
        bus_if.hit_number_pulse = 1'b1;
        bus_if.startOfFrame     = 1'b1;
        tick();
        bus_if.hit_number_pulse = 1'b0;
        bus_if.startOfFrame     = 1'b0;
        chk("hit_at_sof", 1'b0);
        do_frame(1'b0, 1'b0, 0);
        e_n = 2;
        chk("hit_next_frame", 1'b0);

        // Both keys in PLAY: only pause honoured
        bus_if.start_key = 1'b1;
        bus_if.pause_key = 1'b1;
        tick();
        e_state = PAUSE;
        chk("both_keys", 1'b0);
        bus_if.start_key = 1'b0;
        bus_if.pause_key = 1'b0;
        tick();
        bus_if.pause_key = 1'b1;
        tick();
        e_state = PLAY;
        chk("resume", 1'b0);
        bus_if.pause_key = 1'b0;
        tick();

        // Reset in the middle of a freeze, key held through reset
        do_frame(1'b0, 1'b0, 2);
        e_lives = 4;
        e_state = FREEZE;
        chk("freeze_again", 1'b1);
        for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b0, 0);
        bus_if.start_key = 1'b1;
        reset = 1'b1;
        tick();
        e_state = IDLE;
        e_n = 0;
        e_lives = 3;
        chk("reset_mid_freeze", 1'b0);
        reset = 1'b0;
        tick();
        tick();
        chk("held_key_no_edge", 1'b0);
        bus_if.start_key = 1'b0;
        tick();
        bus_if.start_key = 1'b1;
        tick();
        e_state = PLAY;
        chk("start_after_reset", 1'b1);
        bus_if.start_key = 1'b0;
        tick();
        chk("play_after_reset", 1'b0);

        // Drain the scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
